// File: rtl/adc_seq_pkg.sv
// ============================================================================
// Module : adc_seq_pkg
// Brief  : Shared FSM state type and width helpers for the ADC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_SCALE  = 3'd5,
        S_EMIT   = 3'd6
    } state_t;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int acc_w(input int power);
        return 16 + power;
    endfunction

    function automatic int prod_w(input int scaling_factor);
        return 16 + $clog2(scaling_factor) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_scaler.sv
// ============================================================================
// Module : adc_scaler
// Brief  : Two-stage multiply/shift converting an averaged code to 0.1 mV.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_scaler
    import adc_seq_pkg::*;
#(
    parameter int SCALING_FACTOR = 79993,
    parameter int SHIFT_FACTOR   = 19,
    parameter int CH_W           = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic [15:0]     i_ave,
    input  logic [CH_W-1:0] i_ch,
    output logic            o_valid,
    output logic [15:0]     o_ave,
    output logic [CH_W-1:0] o_ch,
    output logic [15:0]     o_mv
);

    localparam int             c_PW = prod_w(SCALING_FACTOR);
    localparam logic [c_PW-1:0] c_SF = c_PW'(SCALING_FACTOR);

    logic [c_PW-1:0] r_prod;
    logic [15:0]     r_ave;
    logic [CH_W-1:0] r_ch;
    logic            r_valid;
    logic [15:0]     w_mv;

    assign w_mv = 16'(r_prod >> SHIFT_FACTOR);

    // Average and channel travel alongside the product so all outputs change together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prod  <= '0;
            r_ave   <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            o_valid <= 1'b0;
            o_ave   <= '0;
            o_ch    <= '0;
            o_mv    <= '0;
        end else begin
            r_valid <= i_valid;
            o_valid <= r_valid;
            if (i_valid) begin
                r_prod <= c_PW'(i_ave) * c_SF;
                r_ave  <= i_ave;
                r_ch   <= i_ch;
            end
            if (r_valid) begin
                o_mv  <= w_mv;
                o_ave <= r_ave;
                o_ch  <= r_ch;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_channel_sequencer.sv
// ============================================================================
// Module : adc_channel_sequencer
// Brief  : Round-robin ADC channel sequencer with averaging and mV scaling.
//          Define ADC_SEQ_DISCARD_EN to drop the first conversion of each visit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int POWER          = 4,
    parameter  int SCALING_FACTOR = 79993,
    parameter  int SHIFT_FACTOR   = 19,
    parameter  int SETTLE_CYCLES  = 16,
    localparam int CH_W           = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              adc_ready,
    input  logic [15:0]       adc_data,
    output logic [CH_W-1:0]   adc_channel,
    output logic              adc_convst,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_ch,
    output logic [15:0]       result_ave,
    output logic [15:0]       result_mv,
    output logic              busy
);

    localparam int c_AW = acc_w(POWER);
    localparam int c_CW = POWER + 1;
    localparam int c_SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_NSAMP       = c_CW'(2 ** POWER);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
`ifdef ADC_SEQ_DISCARD_EN
    localparam logic c_DISCARD = 1'b1;
`else
    localparam logic c_DISCARD = 1'b0;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [CH_W-1:0] r_chan;
    logic            r_have_last;
    logic [c_AW-1:0] r_acc;
    logic [c_CW-1:0] r_cnt;
    logic [c_SW-1:0] r_settle;
    logic            r_ready_d;
    logic            r_discard;
    logic [15:0]     r_ave;
    logic            r_ave_valid;
    logic            w_edge;
    logic            w_convst;
    logic            w_found;
    logic [CH_W-1:0] w_pick;
    int              w_start;
    int              w_idx;

    assign w_edge      = adc_ready & ~r_ready_d;
    assign adc_channel = r_chan;
    assign adc_convst  = w_convst;
    assign busy        = (r_state != S_IDLE);

    // Round-robin search begins one past the last served channel (channel 0 after reset).
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_start = r_have_last ? int'(r_chan) + 1 : 0;
        w_idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = w_start + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (!w_found && ch_mask[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_convst = 1'b0;
        unique case (r_state)
            S_IDLE:   if (enable && (|ch_mask)) w_next = S_SELECT;
            S_SELECT: w_next = w_found ? S_SETTLE : S_IDLE;
            S_SETTLE: if (r_settle == c_SETTLE_LAST) w_next = S_START;
            S_START: begin
                w_convst = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (w_edge) begin
                    if (r_discard || (r_cnt + c_CW'(1) != c_NSAMP)) begin
                        w_next = S_START;
                    end else begin
                        w_next = S_SCALE;
                    end
                end
            end
            S_SCALE:  w_next = S_EMIT;
            S_EMIT:   w_next = enable ? S_SELECT : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_chan      <= '0;
            r_have_last <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_settle    <= '0;
            r_ready_d   <= 1'b0;
            r_discard   <= 1'b0;
            r_ave       <= '0;
            r_ave_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ready_d   <= adc_ready;
            r_ave_valid <= (r_state == S_SCALE);
            unique case (r_state)
                S_SELECT: begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_settle  <= '0;
                    r_discard <= c_DISCARD;
                    if (w_found) begin
                        r_chan      <= w_pick;
                        r_have_last <= 1'b1;
                    end
                end
                S_SETTLE: r_settle <= r_settle + c_SW'(1);
                S_WAIT: begin
                    if (w_edge) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                        end else begin
                            r_acc <= r_acc + c_AW'(adc_data);
                            r_cnt <= r_cnt + c_CW'(1);
                        end
                    end
                end
                S_SCALE:  r_ave <= 16'(r_acc >> POWER);
                default:  ;
            endcase
        end
    end

    adc_scaler #(
        .SCALING_FACTOR (SCALING_FACTOR),
        .SHIFT_FACTOR   (SHIFT_FACTOR),
        .CH_W           (CH_W)
    ) u_scaler (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_ave_valid),
        .i_ave   (r_ave),
        .i_ch    (r_chan),
        .o_valid (result_valid),
        .o_ave   (result_ave),
        .o_ch    (result_ch),
        .o_mv    (result_mv)
    );

endmodule

`default_nettype wire

// File: tb/tb_adc_channel_sequencer.sv
// ============================================================================
// Module : tb_adc_channel_sequencer
// Brief  : Randomised self-checking bench with an ADC responder and a
//          behavioural sequencing/averaging model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_channel_sequencer;

    localparam int NUM_CH = 4;
    localparam int NSAMP  = 4;
    localparam int SETTLE = 4;
`ifdef ADC_SEQ_DISCARD_EN
    localparam int DISC = 1;
`else
    localparam int DISC = 0;
`endif
    localparam int GROUP = NSAMP + DISC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  ch_mask = 4'b0;
    logic        adc_ready = 1'b0;
    logic [15:0] adc_data = 16'h0;
    logic [1:0]  adc_channel;
    logic        adc_convst;
    logic        result_valid;
    logic [1:0]  result_ch;
    logic [15:0] result_ave;
    logic [15:0] result_mv;
    logic        busy;

    adc_channel_sequencer #(
        .NUM_CH         (NUM_CH),
        .POWER          (2),
        .SCALING_FACTOR (79993),
        .SHIFT_FACTOR   (19),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .adc_ready    (adc_ready),
        .adc_data     (adc_data),
        .adc_channel  (adc_channel),
        .adc_convst   (adc_convst),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_ave   (result_ave),
        .result_mv    (result_mv),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    int q_rch[$], q_rave[$], q_rmv[$], q_rcyc[$];
    int q_feed[$], q_deliv[$], q_rise[$];
    int n_convst = 0;
    bit feed_rand = 1'b0;
    int feed_const = 0;
    int rsp_d;

    // Result / convst monitor
    initial forever begin
        @(posedge clk); #1;
        if (result_valid === 1'b1) begin
            q_rch.push_back(int'(result_ch));
            q_rave.push_back(int'(result_ave));
            q_rmv.push_back(int'(result_mv));
            q_rcyc.push_back(cyc);
        end
        if (adc_convst === 1'b1) n_convst++;
    end

    // ADC model: drops ready on convst, raises it with fresh data 2..5 clk later
    initial forever begin
        @(posedge clk); #1;
        if (adc_convst === 1'b1) begin
            adc_ready = 1'b0;
            repeat ($urandom_range(5, 2)) @(posedge clk);
            #1;
            if (q_feed.size() > 0) rsp_d = q_feed.pop_front();
            else if (feed_rand)    rsp_d = int'($urandom_range(65535, 0));
            else                   rsp_d = feed_const;
            adc_data  = 16'(rsp_d);
            adc_ready = 1'b1;
            q_deliv.push_back(rsp_d);
            q_rise.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d results", q_rch.size());
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    function automatic int rr_next(input logic [3:0] m, input int last);
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (last + 1 + k) % NUM_CH;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic int model_ave(input int visit);
        int sum;
        sum = 0;
        for (int s = 0; s < NSAMP; s++) sum += q_deliv[visit * GROUP + DISC + s];
        return sum / NSAMP;
    endfunction

    function automatic int model_mv(input int ave);
        longint p;
        p = longint'(ave) * 64'sd79993;
        return int'(p / 524288);
    endfunction

    // ---------------- helpers (stimulus / bounded waits) ----------------
    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; ch_mask = 4'b0;
        repeat (8) @(posedge clk);
        #2;
        q_rch.delete(); q_rave.delete(); q_rmv.delete(); q_rcyc.delete();
        q_feed.delete(); q_deliv.delete(); q_rise.delete();
        n_convst = 0; feed_rand = 1'b0; feed_const = 0;
        reset = 1'b1;
    endtask

    task automatic wait_results(input int n, input int budget, input string name);
        while (q_rch.size() < n && budget > 0) begin
            @(posedge clk); #2; budget--;
        end
        if (q_rch.size() < n) begin
            n_total++;
            $display("FAIL %s: timeout, got %0d results, required %0d", name, q_rch.size(), n);
        end
    endtask

    task automatic wait_convst(input int n, input int budget, input string name);
        while (n_convst < n && budget > 0) begin
            @(posedge clk); #2; budget--;
        end
        if (n_convst < n) begin
            n_total++;
            $display("FAIL %s: timeout, got %0d convst, required %0d", name, n_convst, n);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        while (busy !== 1'b0 && budget > 0) begin
            @(posedge clk); #2; budget--;
        end
        if (busy !== 1'b0) begin
            n_total++;
            $display("FAIL %s: timeout waiting for idle, busy=%b", name, busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; ch_mask = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
        n_total++; if (adc_convst !== 1'b0) $display("FAIL rst_convst: got %b, required 0", adc_convst); else n_pass++;
        n_total++; if (adc_channel !== 2'd0) $display("FAIL rst_channel: got %0d, required 0", adc_channel); else n_pass++;
        n_total++; if (result_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", result_valid); else n_pass++;
        n_total++;
        if ({result_ch, result_ave, result_mv} !== 34'd0)
            $display("FAIL rst_results: got ch=%0d ave=%0d mv=%0d, required 0", result_ch, result_ave, result_mv);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int last;
        int ea;
        do_reset();
        feed_const = 16'hFFFF;
        ch_mask = 4'b0101;
        enable = 1'b1;
        wait_results(4, 3000, "rr_wait");
        enable = 1'b0;
        wait_idle(500, "rr_idle");
        last = -1;
        for (int i = 0; i < q_rch.size(); i++) begin
            ea = model_ave(i);
            last = rr_next(ch_mask, last);
            n_total++; if (q_rch[i] !== last) $display("FAIL rr_ch[%0d]: got %0d, required %0d", i, q_rch[i], last); else n_pass++;
            n_total++; if (q_rave[i] !== 65535) $display("FAIL rr_ave[%0d]: got %0d, required 65535", i, q_rave[i]); else n_pass++;
            n_total++; if (q_rmv[i] !== 9998) $display("FAIL rr_mv[%0d]: got %0d, required 9998", i, q_rmv[i]); else n_pass++;
            n_total++; if (q_rave[i] !== ea) $display("FAIL rr_model_ave[%0d]: got %0d, required %0d", i, q_rave[i], ea); else n_pass++;
        end
    endtask

    task automatic test_average_timing();
        do_reset();
        if (DISC != 0) q_feed.push_back(999);
        q_feed.push_back(100); q_feed.push_back(200); q_feed.push_back(300); q_feed.push_back(400);
        ch_mask = 4'b0001;
        enable = 1'b1;
        wait_convst(1, 200, "avg_convst");
        enable = 1'b0;
        wait_results(1, 500, "avg_wait");
        if (q_rch.size() >= 1 && q_rise.size() >= GROUP) begin
            n_total++; if (q_rave[0] !== 250) $display("FAIL avg_ave: got %0d, required 250", q_rave[0]); else n_pass++;
            n_total++; if (q_rmv[0] !== 38) $display("FAIL avg_mv: got %0d, required 38", q_rmv[0]); else n_pass++;
            n_total++;
            if (q_rcyc[0] !== q_rise[GROUP-1] + 4)
                $display("FAIL avg_latency: valid at cycle %0d, required %0d", q_rcyc[0], q_rise[GROUP-1] + 4);
            else n_pass++;
        end
        wait_idle(200, "avg_idle");
    endtask

    task automatic test_random();
        int last;
        int ea;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            feed_rand = 1'b1;
            ch_mask = 4'($urandom_range(15, 1));
            enable = 1'b1;
            wait_results(6, 5000, "rand_wait");
            enable = 1'b0;
            wait_idle(500, "rand_idle");
            last = -1;
            for (int i = 0; i < q_rch.size(); i++) begin
                ea = model_ave(i);
                last = rr_next(ch_mask, last);
                n_total++; if (q_rch[i] !== last) $display("FAIL rand_ch[%0d]: got %0d, required %0d", i, q_rch[i], last); else n_pass++;
                n_total++; if (q_rave[i] !== ea) $display("FAIL rand_ave[%0d]: got %0d, required %0d", i, q_rave[i], ea); else n_pass++;
                n_total++; if (q_rmv[i] !== model_mv(ea)) $display("FAIL rand_mv[%0d]: got %0d, required %0d", i, q_rmv[i], model_mv(ea)); else n_pass++;
            end
        end
    endtask

    task automatic test_mask_zero();
        int seen_busy;
        do_reset();
        feed_rand = 1'b1;
        enable = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            if (busy !== 1'b0) seen_busy++;
        end
        n_total++; if (seen_busy !== 0) $display("FAIL mask0_busy: busy cycles %0d, required 0", seen_busy); else n_pass++;
        n_total++; if (n_convst !== 0) $display("FAIL mask0_convst: got %0d pulses, required 0", n_convst); else n_pass++;
        ch_mask = 4'b1000;
        wait_results(1, 500, "mask8_wait");
        enable = 1'b0;
        if (q_rch.size() >= 1) begin
            n_total++; if (q_rch[0] !== 3) $display("FAIL mask8_ch: got %0d, required 3", q_rch[0]); else n_pass++;
        end
        wait_idle(500, "mask8_idle");
    endtask

    task automatic test_enable_drop();
        int base;
        int ea;
        do_reset();
        feed_rand = 1'b1;
        ch_mask = 4'b0011;
        enable = 1'b1;
        wait_results(1, 1000, "drop_first");
        base = n_convst;
        wait_convst(base + DISC + 2, 500, "drop_convst");
        enable = 1'b0;
        wait_idle(500, "drop_idle");
        repeat (50) @(posedge clk);
        #2;
        n_total++; if (q_rch.size() !== 2) $display("FAIL drop_count: got %0d results, required 2", q_rch.size()); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b, required 0", busy); else n_pass++;
        if (q_rch.size() >= 2) begin
            ea = model_ave(1);
            n_total++; if (q_rch[1] !== 1) $display("FAIL drop_ch: got %0d, required 1", q_rch[1]); else n_pass++;
            n_total++; if (q_rave[1] !== ea) $display("FAIL drop_ave: got %0d, required %0d", q_rave[1], ea); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed_const = 123;
        ch_mask = 4'b0001;
        enable = 1'b1;
        wait_convst(1, 200, "mid_convst");
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;
        n_total++;
        if ({busy, adc_convst, adc_channel, result_valid, result_ch, result_ave, result_mv} !== 39'd0)
            $display("FAIL mid_outputs: got busy=%b convst=%b ch=%0d valid=%b rch=%0d ave=%0d mv=%0d, required all 0",
                     busy, adc_convst, adc_channel, result_valid, result_ch, result_ave, result_mv);
        else n_pass++;
        reset = 1'b1;
        enable = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        n_total++; if (q_rch.size() !== 0) $display("FAIL mid_novalid: got %0d results, required 0", q_rch.size()); else n_pass++;
    endtask

    task automatic test_discard();
        do_reset();
        if (DISC != 0) q_feed.push_back(16'hFFFF);
        q_feed.push_back(0); q_feed.push_back(0); q_feed.push_back(0); q_feed.push_back(16'h8000);
        ch_mask = 4'b0001;
        enable = 1'b1;
        wait_convst(1, 200, "disc_convst");
        enable = 1'b0;
        wait_results(1, 500, "disc_wait");
        wait_idle(200, "disc_idle");
        n_total++; if (n_convst !== GROUP) $display("FAIL disc_pulses: got %0d, required %0d", n_convst, GROUP); else n_pass++;
        if (q_rch.size() >= 1) begin
            n_total++; if (q_rave[0] !== 8192) $display("FAIL disc_ave: got %0d, required 8192", q_rave[0]); else n_pass++;
            n_total++; if (q_rmv[0] !== model_mv(8192)) $display("FAIL disc_mv: got %0d, required %0d", q_rmv[0], model_mv(8192)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_average_timing();
        test_random();
        test_mask_zero();
        test_enable_drop();
        test_reset_mid();
        test_discard();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
